// File: rtl/edge_event_counter.sv
// ---------------------------------------------------------------------------------------------
// edge_event_counter
//
// Multi-channel edge counter. Each asynchronous input is synchronised to clk, compared against
// its previous synchronised sample to find rising and falling edges, and the edges are turned
// into registered one-cycle pulses. A per-channel event counter counts the edges selected by
// mode, either wrapping or saturating at its maximum, with a sticky overflow flag.
//
// Parameters
//   N_CH        number of input channels (>= 1)
//   CNT_W       width of each event counter (>= 2)
//   SYNC_STAGES synchroniser flops per channel (>= 2)
//   SATURATE    0: counter wraps max -> 0, 1: counter holds at max
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   sig_in     in   asynchronous event inputs, one bit per channel
//   mode       in   00 rising, 01 falling, 10 both, 11 counting disabled
//   clr        in   synchronous clear of all counters and overflow flags
//   rise_pulse out  one-cycle pulse per detected rising edge (independent of mode)
//   fall_pulse out  one-cycle pulse per detected falling edge (independent of mode)
//   counts     out  packed counters, channel i at [i*CNT_W +: CNT_W]
//   ovf        out  sticky overflow flag per channel
// ---------------------------------------------------------------------------------------------
module edge_event_counter #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sig_in,
    input  logic [1:0]              mode,
    input  logic                    clr,
    output logic [N_CH-1:0]         rise_pulse,
    output logic [N_CH-1:0]         fall_pulse,
    output logic [N_CH*CNT_W-1:0]   counts,
    output logic [N_CH-1:0]         ovf
);

    typedef enum logic [1:0] {
        ModeRise = 2'b00,
        ModeFall = 2'b01,
        ModeBoth = 2'b10,
        ModeOff  = 2'b11
    } mode_e;

    // Detection stays off until the synchroniser and the previous-sample register both hold
    // levels captured after reset release.
    localparam int unsigned ArmCycles = SYNC_STAGES + 1;
    localparam int unsigned ArmW      = $clog2(ArmCycles + 1);
    localparam logic [ArmW-1:0]  ArmDone = ArmW'(ArmCycles);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------------------------
    // Synchroniser, previous sample and arming counter
    // ------------------------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  prev_q;
    logic [ArmW-1:0]                  arm_cnt_q;
    logic                             armed;
    logic [N_CH-1:0]                  sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign armed  = (arm_cnt_q == ArmDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt_q <= '0;
        end else if (!armed) begin
            arm_cnt_q <= arm_cnt_q + ArmW'(1);
        end
    end

    // ------------------------------------------------------------------------------------------
    // Edge detection and registered pulses
    // ------------------------------------------------------------------------------------------
    logic [N_CH-1:0] rise_det;
    logic [N_CH-1:0] fall_det;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] fall_q;

    assign rise_det = armed ? (sync_s & ~prev_q) : '0;
    assign fall_det = armed ? (~sync_s & prev_q) : '0;

    // clr deliberately does not touch the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_det;
            fall_q <= fall_det;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

    // ------------------------------------------------------------------------------------------
    // Event selection
    // ------------------------------------------------------------------------------------------
    logic [N_CH-1:0] evt;

    always_comb begin
        evt = '0;
        unique case (mode_e'(mode))
            ModeRise: evt = rise_det;
            ModeFall: evt = fall_det;
            ModeBoth: evt = rise_det | fall_det;
            ModeOff:  evt = '0;
            default:  evt = '0;
        endcase
    end

    // ------------------------------------------------------------------------------------------
    // Counters and sticky overflow
    // ------------------------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_d;

    // The counter updates on the same edge that registers the pulse for that edge.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr) begin
            // clr wins over an event arriving on the same edge; the event is dropped.
            ovf_d = '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (evt[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = SATURATE ? CntMax : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign ovf = ovf_q;

endmodule
